// File: rtl/aes_decrypt_iter_if.sv
// Handshake and data bundle between a ciphertext source, the AES-128
// iterative decryptor and a plaintext sink.
interface aes_decrypt_iter_if #(
   parameter int unsigned KEY_W = 1408
);
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in;
   logic [KEY_W-1:0] w;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out;

   // Requester side: offers ciphertext and key schedule, sinks plaintext.
   modport master (
      output in_valid,
      output in,
      output w,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out
   );

   // Decryptor side.
   modport slave (
      input  in_valid,
      input  in,
      input  w,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out
   );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock on a single state
// register, valid/ready on both sides, no overlap between blocks.
module aes_decrypt_iter #(
   parameter int unsigned NR    = 10,
   parameter int unsigned KEY_W = 4 * (NR + 1) * 32
) (
   input logic               clk,
   input logic               reset,
   aes_decrypt_iter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRound, StHold} state_e;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   state_e       state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] data_q, data_d;
   logic [127:0] rk;
   logic [127:0] shifted;
   logic [127:0] subbed;
   logic [127:0] added;
   logic [127:0] mixed;

   // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte k of the state is s(k%4, k/4); byte 0 sits in the top bits.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            r[127 - 8 * (4 * c + rr) -: 8] = s[127 - 8 * (4 * ((c + 4 - rr) % 4) + rr) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         r[127 - 8 * k -: 8] = INV_SBOX[s[127 - 8 * k -: 8]];
      end
      return r;
   endfunction

   // Column times {0e,0b,0d,09} built from repeated xtime.
   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a  [4];
      logic [7:0]   m9 [4];
      logic [7:0]   mb [4];
      logic [7:0]   md [4];
      logic [7:0]   me [4];
      logic [7:0]   x2, x4, x8;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            a[i]  = s[127 - 8 * (4 * c + i) -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
         end
         r[127 - 8 * (4 * c)     -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         r[127 - 8 * (4 * c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         r[127 - 8 * (4 * c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         r[127 - 8 * (4 * c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
      return r;
   endfunction

   // Round datapath: select the key for the current round and apply one inverse round.
   always_comb begin
      rk = '0;
      for (int i = 0; i <= int'(NR); i++) begin
         if (rnd_q == 4'(i)) begin
            rk = bus.w[KEY_W - 1 - 128 * i -: 128];
         end
      end
      shifted = inv_shift_rows(data_q);
      subbed  = inv_sub_bytes(shifted);
      added   = subbed ^ rk;
      mixed   = inv_mix_columns(added);
   end

   // Next-state logic for the FSM, round counter and state register.
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               data_d  = bus.in ^ bus.w[127:0];
               rnd_d   = 4'(NR - 1);
               state_d = StRound;
            end
         end
         StRound: begin
            if (rnd_q == 4'd0) begin
               // Final round skips InvMixColumns.
               data_d  = added;
               state_d = StHold;
            end else begin
               data_d = mixed;
               rnd_d  = rnd_q - 4'd1;
            end
         end
         StHold: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         rnd_q   <= 4'd0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         data_q  <= data_d;
      end
   end

   // Handshake flags depend on state only; the result stays in the state register.
   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StHold);
   assign bus.out       = data_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter: a forward AES-128 model builds
// ciphertext, expected plaintexts are queued and checked by a monitor.
module tb_aes_decrypt_iter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   aes_decrypt_iter_if #(.KEY_W(1408)) bus ();

   aes_decrypt_iter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           acc_cyc  = -100;
   int           hs_cyc   = -100;
   bit           rnd_ready_en = 1'b0;
   logic [127:0] exp_q [$];
   logic [7:0]   sbox_t [256];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual event missing required event seen", name);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Forward S-box from its definition: GF inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [1407:0] key_expand(input logic [127:0] key);
      logic [31:0]   wd [44];
      logic [31:0]   t;
      logic [7:0]    rcon = 8'h01;
      logic [1407:0] r;
      for (int i = 0; i < 4; i++) wd[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = wd[i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t = t ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         wd[i] = wd[i - 4] ^ t;
      end
      for (int i = 0; i < 44; i++) r[1407 - 32 * i -: 32] = wd[i];
      return r;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] wb);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] st;
      st = pt ^ wb[1407 -: 128];
      for (int r = 1; r <= 10; r++) begin
         for (int k = 0; k < 16; k++) s[k] = sbox_t[st[127 - 8 * k -: 8]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4 * c + rr] = s[4 * ((c + rr) % 4) + rr];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
               t[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               t[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               t[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               t[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int k = 0; k < 16; k++) st[127 - 8 * k -: 8] = t[k];
         st = st ^ wb[1407 - 128 * r -: 128];
      end
      return st;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic         prev_valid;
      logic [127:0] prev_out;
      prev_valid = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
            if (bus.out_valid) begin
               check("in_ready_in_hold", {127'd0, bus.in_ready}, 128'd0);
               if (!prev_valid) check("latency", 128'(cyc - acc_cyc), 128'd10);
               else check("out_stable", bus.out, prev_out);
               if (bus.out_ready) begin
                  hs_cyc = cyc + 1;
                  if (exp_q.size() == 0) fail_now("unexpected_output");
                  else check("plaintext", bus.out, exp_q.pop_front());
               end
            end
            prev_valid = bus.out_valid;
            prev_out   = bus.out;
         end
      end
   end

   // Random sink backpressure for the round-trip phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready_en) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] ct, input logic [1407:0] wb, input logic [127:0] pt);
      bit ok = 1'b0;
      exp_q.push_back(pt);
      bus.in       = ct;
      bus.w        = wb;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      if (!ok) fail_now("accept_timeout");
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
      end
      tick();
      if (!ok) fail_now("idle_timeout");
   endtask

   // Returns at a falling edge with out_valid high.
   task automatic wait_out();
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.out_valid) ok = 1'b1;
      end
      if (!ok) fail_now("out_valid_timeout");
   endtask

   localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;

   initial begin : main
      logic [1407:0] wc1, wb, wr;
      logic [127:0]  pa, pb, kr, pr;

      build_sbox();
      wc1 = key_expand(C1Key);
      wb  = key_expand(BKey);

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in        = '0;
      bus.w         = '0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
      check("reset_out", bus.out, 128'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
      tick();

      // FIPS-197 C.1 with the sink always ready; out_valid lasts one cycle.
      bus.out_ready = 1'b1;
      send(C1Ct, wc1, C1Pt);
      wait_out();
      @(negedge clk);
      check("valid_one_cycle", {127'd0, bus.out_valid}, 128'd0);
      check("in_ready_after_c1", {127'd0, bus.in_ready}, 128'd1);
      tick();

      // FIPS-197 Appendix B.
      send(BCt, wb, BPt);
      wait_idle();

      // Backpressure: sink stalls for five cycles.
      bus.out_ready = 1'b0;
      send(BCt, wb, BPt);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", {127'd0, bus.out_valid}, 128'd1);
         check("bp_in_ready", {127'd0, bus.in_ready}, 128'd0);
      end
      tick();
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_single_transfer", {127'd0, bus.out_valid}, 128'd0);
      check("bp_in_ready_after", {127'd0, bus.in_ready}, 128'd1);
      tick();

      // Busy input: a different block offered mid-round must be dropped.
      send(C1Ct, wc1, C1Pt);
      repeat (3) tick();
      bus.in       = BCt;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_idle();
      repeat (3) tick();

      // Back-to-back blocks under one key with in_valid held high.
      pa = {$urandom(), $urandom(), $urandom(), $urandom()};
      pb = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(encrypt(pa, wb), wb, pa);
      send(encrypt(pb, wb), wb, pb);
      check("b2b_accept_gap", 128'(acc_cyc - hs_cyc), 128'd1);
      wait_idle();

      // Reset during round 5 abandons the block.
      send(C1Ct, wc1, C1Pt);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midreset_out_valid", {127'd0, bus.out_valid}, 128'd0);
      check("midreset_out", bus.out, 128'd0);
      check("midreset_in_ready", {127'd0, bus.in_ready}, 128'd1);
      tick();
      send(C1Ct, wc1, C1Pt);
      wait_idle();

      // Round trip of random plaintext/key pairs with random sink stalls.
      rnd_ready_en = 1'b1;
      for (int n = 0; n < 100; n++) begin
         kr = {$urandom(), $urandom(), $urandom(), $urandom()};
         pr = {$urandom(), $urandom(), $urandom(), $urandom()};
         wr = key_expand(kr);
         repeat ($urandom_range(0, 2)) tick();
         send(encrypt(pr, wr), wr, pr);
         wait_idle();
      end
      rnd_ready_en = 1'b0;
      tick();
      bus.out_ready = 1'b1;
      repeat (5) tick();
      check("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
